// File: rtl/wheel_adc_reader.sv
// Wheel position reader: drives MAX10 modular-ADC conversions on one channel,
// averages 2^AVG_LOG2 samples, and applies a deadband before publishing the wheel value.
module wheel_adc_reader #(
  parameter int CHANNEL  = 5,
  parameter int AVG_LOG2 = 3,
  parameter int DEADBAND = 2,
  parameter int INTERVAL = 1024,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        reset,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic [11:0] wheel,
  output logic        wheel_valid,
  output logic [7:0]  timeout_cnt,
  output logic        busy
);

  localparam int IW = (INTERVAL > 0) ? $clog2(INTERVAL + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  localparam logic [IW-1:0] INTERVAL_LD = IW'(INTERVAL);
  localparam logic [TW-1:0] TIMEOUT_LD  = TW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_FULL    = CW'(1 << AVG_LOG2);
  localparam logic [4:0]    CHAN        = 5'(CHANNEL);
  localparam logic [12:0]   BAND        = 13'(DEADBAND);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RESP
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] interval_cnt, interval_next;
  logic [TW-1:0] resp_cnt, resp_next;
  logic [AW-1:0] acc, acc_next, acc_sum;
  logic [CW-1:0] smp_cnt, cnt_next, cnt_inc;
  logic          first_flag, first_next;
  logic [11:0]   wheel_next, avg;
  logic          wheel_valid_next;
  logic [7:0]    timeout_next;
  logic [12:0]   diff;

  assign command_channel       = CHAN;
  assign command_startofpacket = 1'b1;
  assign command_endofpacket   = 1'b1;
  assign busy                  = (state == S_CMD) || (state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      interval_cnt <= INTERVAL_LD;
      resp_cnt     <= '0;
      acc          <= '0;
      smp_cnt      <= '0;
      first_flag   <= 1'b1;
      wheel        <= '0;
      wheel_valid  <= 1'b0;
      timeout_cnt  <= '0;
    end else begin
      state        <= state_next;
      interval_cnt <= interval_next;
      resp_cnt     <= resp_next;
      acc          <= acc_next;
      smp_cnt      <= cnt_next;
      first_flag   <= first_next;
      wheel        <= wheel_next;
      wheel_valid  <= wheel_valid_next;
      timeout_cnt  <= timeout_next;
    end
  end

  // A completed average is evaluated on the same edge that accepts its last sample.
  always_comb begin
    state_next       = state;
    interval_next    = interval_cnt;
    resp_next        = resp_cnt;
    acc_next         = acc;
    cnt_next         = smp_cnt;
    first_next       = first_flag;
    wheel_next       = wheel;
    wheel_valid_next = 1'b0;
    timeout_next     = timeout_cnt;
    command_valid    = 1'b0;
    acc_sum          = acc + AW'(response_data);
    cnt_inc          = smp_cnt + 1'b1;
    avg              = acc_sum[AW-1:AVG_LOG2];
    diff             = (avg >= wheel) ? ({1'b0, avg} - {1'b0, wheel})
                                      : ({1'b0, wheel} - {1'b0, avg});

    case (state)
      S_IDLE: begin
        if (interval_cnt == '0) begin
          state_next = S_CMD;
        end else begin
          interval_next = interval_cnt - 1'b1;
        end
      end
      S_CMD: begin
        command_valid = 1'b1;
        if (command_ready) begin
          state_next = S_RESP;
          resp_next  = '0;
        end
      end
      S_RESP: begin
        // A matching response takes priority over a coincident timeout.
        if (response_valid && (response_channel == CHAN)) begin
          state_next    = S_IDLE;
          interval_next = INTERVAL_LD;
          if (cnt_inc == CNT_FULL) begin
            acc_next = '0;
            cnt_next = '0;
            if (first_flag || (diff > BAND)) begin
              wheel_next       = avg;
              wheel_valid_next = 1'b1;
              first_next       = 1'b0;
            end
          end else begin
            acc_next = acc_sum;
            cnt_next = cnt_inc;
          end
        end else if (resp_cnt == TIMEOUT_LD) begin
          state_next    = S_IDLE;
          interval_next = INTERVAL_LD;
          if (timeout_cnt != 8'hFF) begin
            timeout_next = timeout_cnt + 1'b1;
          end
        end else begin
          resp_next = resp_cnt + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
